img_uart_streamer: RTL and testbench

- Reads a stored WIDTH×HEIGHT greyscale image out of a BRAM read port and serialises it over UART, one pixel per 8N1 frame, in raster order (address 0 first).
- Transmit-side counterpart of the UART-receive-into-BRAM path.
- Sits between the blurred-image BRAM port B and uart_txd.
- Prefetches the next pixel during the current frame, so frames go back-to-back with no idle gap.

---
 rtl/img_uart_streamer.sv | 196 +++++++++++++++++++
 tb/tb_img_uart_streamer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/img_uart_streamer.sv
// ---------------------------------------------------------------------------
// img_uart_streamer
//
// Streams a stored WIDTH x HEIGHT greyscale image out of a BRAM read port as
// back-to-back 8N1 UART frames, one pixel per frame, in raster order.  The
// next pixel is fetched while the current frame is on the wire, so there is
// no idle time between frames.
//
// Ports
//   clk_in           system clock
//   rst_in           asynchronous reset, active low
//   start_in         single-cycle request to stream the whole image
//   read_addr        BRAM read address
//   read_addr_valid  BRAM read enable (one-cycle pulses)
//   pixel_in         BRAM read data, valid BRAM_LATENCY cycles after a read
//   tx               UART line, idles high
//   busy             high while a stream is in progress
//   done             one-cycle pulse when the last stop bit has completed
// ---------------------------------------------------------------------------
module img_uart_streamer #(
    parameter int WIDTH           = 64,
    parameter int HEIGHT          = 64,
    parameter int BIT_DEPTH       = 8,
    parameter int CLOCKS_PER_BAUD = 50,
    parameter int BRAM_LATENCY    = 2
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              start_in,
    output logic [$clog2(WIDTH*HEIGHT)-1:0]   read_addr,
    output logic                              read_addr_valid,
    input  logic [BIT_DEPTH-1:0]              pixel_in,
    output logic                              tx,
    output logic                              busy,
    output logic                              done
);

    localparam int NUM_PIXELS = WIDTH * HEIGHT;
    localparam int AW         = $clog2(NUM_PIXELS);
    localparam int BW         = $clog2(CLOCKS_PER_BAUD);

    localparam logic [AW-1:0] LAST_PIX  = AW'(NUM_PIXELS - 1);
    localparam logic [BW-1:0] LAST_BAUD = BW'(CLOCKS_PER_BAUD - 1);
    localparam logic [3:0]    STOP_BIT  = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  state_reg;
    state_t                  state_next;
    logic                    prime_issue_reg;   // first cycle of PRIME
    logic [BRAM_LATENCY-1:0] fetch_pipe_reg;    // tracks the read in flight
    logic [BW-1:0]           baud_cnt_reg;
    logic [3:0]              bit_cnt_reg;       // 0 start, 1..8 data, 9 stop
    logic [AW-1:0]           pix_idx_reg;       // pixel currently on the wire
    logic [7:0]              shift_reg;         // byte being transmitted
    logic [7:0]              hold_reg;          // prefetched next byte

    logic       more_pixels;
    logic       prefetch_issue;
    logic       read_issue;
    logic       data_arrive;
    logic       frame_end;
    logic [2:0] data_bit_idx;

    assign more_pixels    = (pix_idx_reg != LAST_PIX);
    // Prefetch is issued on the very first cycle of each start bit.
    assign prefetch_issue = (state_reg == SEND) && (bit_cnt_reg == 4'd0) &&
                            (baud_cnt_reg == '0) && more_pixels;
    assign read_issue     = ((state_reg == PRIME) && prime_issue_reg) || prefetch_issue;
    // Only one read is ever outstanding, so the pipe's tail marks valid data.
    assign data_arrive    = fetch_pipe_reg[BRAM_LATENCY-1];
    assign frame_end      = (state_reg == SEND) && (bit_cnt_reg == STOP_BIT) &&
                            (baud_cnt_reg == LAST_BAUD);
    assign data_bit_idx   = 3'(bit_cnt_reg - 4'd1);

    // ---------------- state register ----------------
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_in)                  state_next = PRIME;
            PRIME:   if (data_arrive)               state_next = SEND;
            SEND:    if (frame_end && !more_pixels) state_next = DONE;
            DONE:                                   state_next = IDLE;
            default:                                state_next = IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        tx              = 1'b1;
        busy            = 1'b0;
        done            = 1'b0;
        read_addr_valid = read_issue;
        // The priming read is address 0; otherwise the address rests at 0.
        read_addr       = prefetch_issue ? (pix_idx_reg + 1'b1) : '0;
        case (state_reg)
            PRIME: busy = 1'b1;
            SEND: begin
                busy = 1'b1;
                if (bit_cnt_reg == 4'd0) begin
                    tx = 1'b0;
                end else if (bit_cnt_reg == STOP_BIT) begin
                    tx = 1'b1;
                end else begin
                    tx = shift_reg[data_bit_idx];
                end
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // ---------------- read tracking pipe ----------------
    generate
        if (BRAM_LATENCY == 1) begin : g_pipe_single
            always_ff @(posedge clk_in or negedge rst_in) begin
                if (!rst_in) begin
                    fetch_pipe_reg <= '0;
                end else begin
                    fetch_pipe_reg <= read_issue;
                end
            end
        end else begin : g_pipe_multi
            always_ff @(posedge clk_in or negedge rst_in) begin
                if (!rst_in) begin
                    fetch_pipe_reg <= '0;
                end else begin
                    fetch_pipe_reg <= {fetch_pipe_reg[BRAM_LATENCY-2:0], read_issue};
                end
            end
        end
    endgenerate

    // ---------------- datapath and counters ----------------
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            prime_issue_reg <= 1'b0;
            baud_cnt_reg    <= '0;
            bit_cnt_reg     <= '0;
            pix_idx_reg     <= '0;
            shift_reg       <= '0;
            hold_reg        <= '0;
        end else begin
            prime_issue_reg <= (state_reg == IDLE) && start_in;
            case (state_reg)
                PRIME: begin
                    baud_cnt_reg <= '0;
                    bit_cnt_reg  <= '0;
                    if (data_arrive) begin
                        shift_reg <= pixel_in[BIT_DEPTH-1 -: 8];
                    end
                end
                SEND: begin
                    if (data_arrive) begin
                        hold_reg <= pixel_in[BIT_DEPTH-1 -: 8];
                    end
                    if (baud_cnt_reg == LAST_BAUD) begin
                        baud_cnt_reg <= '0;
                        if (bit_cnt_reg == STOP_BIT) begin
                            bit_cnt_reg <= '0;
                            // Next frame starts on the following cycle.
                            if (more_pixels) begin
                                shift_reg   <= hold_reg;
                                pix_idx_reg <= pix_idx_reg + 1'b1;
                            end
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 4'd1;
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    baud_cnt_reg <= '0;
                    bit_cnt_reg  <= '0;
                    pix_idx_reg  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_img_uart_streamer.sv
module tb_img_uart_streamer;

    localparam int W         = 4;
    localparam int H         = 2;
    localparam int N         = W * H;
    localparam int AW        = 3;
    localparam int CPB       = 4;
    localparam int LAT       = 2;
    localparam int FRAME     = 10 * CPB;
    // Capture sample i is taken in cycle (start cycle + 1 + i).
    localparam int FIRST_LOW = (1 + LAT + 1) - 1;
    localparam int DONE_IDX  = (2 + LAT + N * FRAME) - 1;
    localparam int CAP_LEN   = DONE_IDX + 17;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          start_a, start_b;
    logic [AW-1:0] ra_a, ra_b;
    logic          rv_a, rv_b;
    logic [7:0]    pix_a;
    logic [9:0]    pix_b;
    logic          tx_a, tx_b, busy_a, busy_b, done_a, done_b;

    img_uart_streamer #(.WIDTH(W), .HEIGHT(H), .BIT_DEPTH(8),
                        .CLOCKS_PER_BAUD(CPB), .BRAM_LATENCY(LAT)) dut_a (
        .clk_in(clk), .rst_in(rst_n), .start_in(start_a),
        .read_addr(ra_a), .read_addr_valid(rv_a), .pixel_in(pix_a),
        .tx(tx_a), .busy(busy_a), .done(done_a));

    img_uart_streamer #(.WIDTH(W), .HEIGHT(H), .BIT_DEPTH(10),
                        .CLOCKS_PER_BAUD(CPB), .BRAM_LATENCY(LAT)) dut_b (
        .clk_in(clk), .rst_in(rst_n), .start_in(start_b),
        .read_addr(ra_b), .read_addr_valid(rv_b), .pixel_in(pix_b),
        .tx(tx_b), .busy(busy_b), .done(done_b));

    // BRAM models: data only valid exactly LAT cycles after a read, X otherwise.
    logic [7:0] mem_a [N];
    logic [9:0] mem_b [N];
    logic [7:0] stg_a;
    logic [9:0] stg_b;
    always @(posedge clk) begin
        stg_a <= rv_a ? mem_a[ra_a] : 8'hxx;
        pix_a <= stg_a;
        stg_b <= rv_b ? mem_b[ra_b] : 10'hxxx;
        pix_b <= stg_b;
    end

    logic          tx_q[$], busy_q[$], done_q[$], rv_q[$];
    logic [AW-1:0] ra_q[$];
    logic [7:0]    exp_bytes [N];
    int            checks = 0;
    int            passed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_start(input int dut, input logic v);
        if (dut == 0) start_a = v;
        else          start_b = v;
    endtask

    // Pulses start on one DUT and records n cycles of its outputs; start is
    // re-asserted for one cycle after samples rp1 and rp2.
    task automatic capture(input int dut, input int n, input int rp1, input int rp2);
        tx_q.delete(); busy_q.delete(); done_q.delete(); rv_q.delete(); ra_q.delete();
        set_start(dut, 1'b1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (dut == 0) begin
                tx_q.push_back(tx_a); busy_q.push_back(busy_a); done_q.push_back(done_a);
                rv_q.push_back(rv_a); ra_q.push_back(ra_a);
            end else begin
                tx_q.push_back(tx_b); busy_q.push_back(busy_b); done_q.push_back(done_b);
                rv_q.push_back(rv_b); ra_q.push_back(ra_b);
            end
            set_start(dut, (i == rp1) || (i == rp2));
        end
    endtask

    task automatic analyze(input string tag);
        int         wave_bad, busy_bad, done_cnt, done_at, first_low, pulses, rd_bad;
        int         j, f, b, exp_idx;
        logic       e;
        logic [7:0] d;
        wave_bad = 0; busy_bad = 0; done_cnt = 0; done_at = -1;
        first_low = -1; pulses = 0; rd_bad = 0;
        for (int i = 0; i < tx_q.size(); i++) begin
            j = i - FIRST_LOW;
            e = 1'b1;
            if (j >= 0 && j < N * FRAME) begin
                f = j / FRAME;
                b = (j % FRAME) / CPB;
                if (b == 0)      e = 1'b0;
                else if (b == 9) e = 1'b1;
                else             e = exp_bytes[f][b-1];
            end
            if (tx_q[i] !== e) wave_bad++;
            if (first_low < 0 && tx_q[i] === 1'b0) first_low = i;
            if (busy_q[i] !== (i < DONE_IDX)) busy_bad++;
            if (done_q[i] === 1'b1) begin
                done_cnt++;
                done_at = i;
            end
            if (rv_q[i] !== 1'b0) begin
                exp_idx = (pulses == 0) ? 0 : FIRST_LOW + (pulses - 1) * FRAME;
                if (i != exp_idx || ra_q[i] !== AW'(pulses)) rd_bad++;
                pulses++;
            end
        end
        for (int k = 0; k < N; k++) begin
            for (int bi = 0; bi < 8; bi++)
                d[bi] = tx_q[FIRST_LOW + k * FRAME + (bi + 1) * CPB + CPB / 2];
            check($sformatf("%s_byte%0d", tag, k), d, exp_bytes[k]);
        end
        $display("%s: first_low=%0d done_at=%0d reads=%0d", tag, first_low, done_at, pulses);
        check({tag, "_tx_wave_errs"}, wave_bad, 0);
        check({tag, "_first_low"}, first_low, FIRST_LOW);
        check({tag, "_done_at"}, done_at, DONE_IDX);
        check({tag, "_done_count"}, done_cnt, 1);
        check({tag, "_busy_errs"}, busy_bad, 0);
        check({tag, "_read_count"}, pulses, N);
        check({tag, "_read_seq_errs"}, rd_bad, 0);
    endtask

    initial begin
        int dcount;
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
        mem_a[0] = 8'h00; mem_a[1] = 8'h01; mem_a[2] = 8'h80; mem_a[3] = 8'hFF;
        mem_a[4] = 8'h55; mem_a[5] = 8'hAA; mem_a[6] = 8'h0F; mem_a[7] = 8'hF0;
        for (int k = 0; k < N; k++) mem_b[k] = 10'($urandom_range(0, 1023));

        repeat (3) @(negedge clk);
        check("rst_tx", tx_a, 1);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_addr", ra_a, 0);
        check("rst_valid", rv_a, 0);
        check("rst_tx_b", tx_b, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Fixed image
        for (int k = 0; k < N; k++) exp_bytes[k] = mem_a[k];
        capture(0, CAP_LEN, -1, -1);
        analyze("fixed");

        // Random image; start re-pulsed during frame 3 and in the done cycle
        for (int k = 0; k < N; k++) begin
            mem_a[k] = 8'($urandom_range(0, 255));
            exp_bytes[k] = mem_a[k];
        end
        capture(0, CAP_LEN, FIRST_LOW + 3 * FRAME + 5, DONE_IDX);
        analyze("repulse");

        // Reset during data bit 2 of frame 5
        capture(0, FIRST_LOW + 5 * FRAME + 3 * CPB + 2, -1, -1);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_tx", tx_a, 1);
        check("midrst_busy", busy_a, 0);
        check("midrst_valid", rv_a, 0);
        dcount = 0;
        foreach (done_q[i]) if (done_q[i] !== 1'b0) dcount++;
        repeat (3) begin
            @(negedge clk);
            if (done_a !== 1'b0) dcount++;
        end
        check("midrst_no_done", dcount, 0);
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            mem_a[k] = 8'($urandom_range(0, 255));
            exp_bytes[k] = mem_a[k];
        end
        capture(0, CAP_LEN, -1, -1);
        analyze("after_rst");

        // 10-bit pixels: the 8 MSBs are transmitted
        mem_b[2] = 10'h3FC;
        mem_b[5] = 10'h203;
        for (int k = 0; k < N; k++) exp_bytes[k] = mem_b[k][9:2];
        capture(1, CAP_LEN, -1, -1);
        analyze("depth10");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
